// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline control slice: hazard FSM states and register ids.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    IWAIT  = 2'd2,
    HALTED = 2'd3
  } hazard_state_t;

  typedef logic [4:0] regbits_t;

  localparam regbits_t REG_ZERO = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous reset and synchronous clear.
module sat_counter #(
  parameter int unsigned   W   = 32,
  parameter logic [W-1:0]  MAX = '1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;

  // Count up on inc, stick at MAX, clear has priority.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, branch flushes,
// memory-wait freezing, halt latching, wait watchdog and perf counters.
module hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned MAX_WAIT = 255,
  parameter int unsigned WAIT_W   = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             ex_memread,
  input  regbits_t         ex_rd,
  input  regbits_t         id_rs,
  input  regbits_t         id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_br_taken,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             halt,
  output logic             mem_timeout,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  hazard_state_t     state_q, state_d;
  logic              halt_q;
  logic              timeout_q;
  logic [WAIT_W-1:0] wait_cnt;

  logic mem_req, advance, load_use, dmiss, active;

  assign mem_req  = mem_dREN | mem_dWEN;
  assign dmiss    = mem_req & ~dhit;
  assign advance  = ihit & (~mem_req | dhit);
  assign load_use = ex_memread & (ex_rd != REG_ZERO) &
                    ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));
  assign active   = (state_q != HALTED);

  // Latch enables/flushes: frozen while waiting, halted or in reset; a pending
  // flush simply waits for the first advancing cycle since nothing moves before it.
  always_comb begin
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_en    = 1'b0;
    idex_flush = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    if (!RST && active && advance) begin
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
      if (ex_br_taken) begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        idex_flush = 1'b1;
      end else begin
        pc_en   = 1'b1;
        ifid_en = 1'b1;
      end
    end
  end

  // Next-state selection in priority order; HALTED is absorbing.
  always_comb begin
    state_d = RUN;
    if (!active || wb_halt) begin
      state_d = HALTED;
    end else if (dmiss) begin
      state_d = DWAIT;
    end else if (!ihit) begin
      state_d = IWAIT;
    end
  end

  // FSM state plus its registered sticky flags.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= RUN;
      halt_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == HALTED) begin
        halt_q <= 1'b1;
      end
      if ((state_q == DWAIT) && (wait_cnt == WAIT_MAX)) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign halt        = halt_q;
  assign mem_timeout = timeout_q;
  assign state_o     = state_q;

  sat_counter #(.W(WAIT_W), .MAX(WAIT_MAX)) u_wait_cnt (
    .CLK (CLK),
    .RST (RST),
    .clr (state_q != DWAIT),
    .inc (state_q == DWAIT),
    .cnt (wait_cnt)
  );

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .CLK (CLK),
    .RST (RST),
    .clr (1'b0),
    .inc (active),
    .cnt (cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK (CLK),
    .RST (RST),
    .clr (1'b0),
    .inc (active & ~pc_en),
    .cnt (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK (CLK),
    .RST (RST),
    .clr (1'b0),
    .inc (ifid_flush),
    .cnt (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; a narrow-counter copy exercises saturation.
`timescale 1ns/1ps
module tb_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        ihit, dhit, mem_dREN, mem_dWEN, ex_memread, id_uses_rt, ex_br_taken, wb_halt;
  logic [4:0]  ex_rd, id_rs, id_rt;

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en}
  logic [6:0]  ctl, s_ctl;
  logic        halt, mem_timeout, s_halt, s_timeout;
  logic [1:0]  state_o, s_state;
  logic [31:0] cycle_cnt, stall_cnt, flush_cnt;
  logic [2:0]  s_cycle, s_stall, s_flush;

  int vecs = 0;
  int errs = 0;

  localparam logic [6:0] C_RUN  = 7'b1101011;
  localparam logic [6:0] C_BR   = 7'b1111111;
  localparam logic [6:0] C_LU   = 7'b0001111;
  localparam logic [6:0] C_HOLD = 7'b0000000;

  always #5 CLK = ~CLK;

  hazard_ctrl #(.CNT_W(32), .MAX_WAIT(4), .WAIT_W(8)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_br_taken(ex_br_taken), .wb_halt(wb_halt),
    .pc_en(ctl[6]), .ifid_en(ctl[5]), .ifid_flush(ctl[4]), .idex_en(ctl[3]),
    .idex_flush(ctl[2]), .exmem_en(ctl[1]), .memwb_en(ctl[0]),
    .halt(halt), .mem_timeout(mem_timeout), .state_o(state_o),
    .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.CNT_W(3), .MAX_WAIT(255), .WAIT_W(8)) dut_small (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_br_taken(ex_br_taken), .wb_halt(wb_halt),
    .pc_en(s_ctl[6]), .ifid_en(s_ctl[5]), .ifid_flush(s_ctl[4]), .idex_en(s_ctl[3]),
    .idex_flush(s_ctl[2]), .exmem_en(s_ctl[1]), .memwb_en(s_ctl[0]),
    .halt(s_halt), .mem_timeout(s_timeout), .state_o(s_state),
    .cycle_cnt(s_cycle), .stall_cnt(s_stall), .flush_cnt(s_flush)
  );

  task automatic idle_inputs();
    ihit = 1'b1; dhit = 1'b0; mem_dREN = 1'b0; mem_dWEN = 1'b0;
    ex_memread = 1'b0; ex_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    id_uses_rt = 1'b0; ex_br_taken = 1'b0; wb_halt = 1'b0;
  endtask

  // Leaves time at posedge+1 with reset released and idle inputs.
  task automatic do_reset();
    idle_inputs();
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    RST = 1'b0; #1; RST = 1'b1; #2;
    vecs++; if (ctl !== C_HOLD) begin errs++; $display("FAIL rst_ctl got %b exp %b", ctl, C_HOLD); end
    vecs++; if (state_o !== 2'd0) begin errs++; $display("FAIL rst_state got %0d exp 0", state_o); end
    vecs++; if ({cycle_cnt, stall_cnt, flush_cnt} !== 96'd0) begin errs++; $display("FAIL rst_cnts got %0d/%0d/%0d exp 0/0/0", cycle_cnt, stall_cnt, flush_cnt); end
    vecs++; if ({halt, mem_timeout} !== 2'b00) begin errs++; $display("FAIL rst_flags got %b exp 00", {halt, mem_timeout}); end
    do_reset();
  endtask

  task automatic test_load_use();
    do_reset();
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; #2;
    vecs++; if (ctl !== C_LU) begin errs++; $display("FAIL lu_ctl got %b exp %b", ctl, C_LU); end
    step();
    vecs++; if (stall_cnt !== 32'd1) begin errs++; $display("FAIL lu_stall got %0d exp 1", stall_cnt); end
    vecs++; if (cycle_cnt !== 32'd1) begin errs++; $display("FAIL lu_cycle got %0d exp 1", cycle_cnt); end
    ex_rd = 5'd0; id_rs = 5'd0; #2;
    vecs++; if (ctl !== C_RUN) begin errs++; $display("FAIL lu_r0_ctl got %b exp %b", ctl, C_RUN); end
    step();
    vecs++; if (stall_cnt !== 32'd1) begin errs++; $display("FAIL lu_r0_stall got %0d exp 1", stall_cnt); end
    vecs++; if (cycle_cnt !== 32'd2) begin errs++; $display("FAIL lu_r0_cycle got %0d exp 2", cycle_cnt); end
  endtask

  task automatic test_rt_gating();
    do_reset();
    ex_memread = 1'b1; ex_rd = 5'd7; id_rs = 5'd3; id_rt = 5'd7; id_uses_rt = 1'b0; #2;
    vecs++; if (ctl !== C_RUN) begin errs++; $display("FAIL rt_off_ctl got %b exp %b", ctl, C_RUN); end
    id_uses_rt = 1'b1; #1;
    vecs++; if (ctl !== C_LU) begin errs++; $display("FAIL rt_on_ctl got %b exp %b", ctl, C_LU); end
    step();
    vecs++; if (stall_cnt !== 32'd1) begin errs++; $display("FAIL rt_stall got %0d exp 1", stall_cnt); end
  endtask

  task automatic test_branch_vs_load_use();
    do_reset();
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; ex_br_taken = 1'b1; #2;
    vecs++; if (ctl !== C_BR) begin errs++; $display("FAIL br_lu_ctl got %b exp %b", ctl, C_BR); end
    step();
    vecs++; if (flush_cnt !== 32'd1) begin errs++; $display("FAIL br_lu_flush got %0d exp 1", flush_cnt); end
    vecs++; if (stall_cnt !== 32'd0) begin errs++; $display("FAIL br_lu_stall got %0d exp 0", stall_cnt); end
    // Branch held across a dcache wait is applied only once the wait ends.
    ex_memread = 1'b0; mem_dREN = 1'b1; dhit = 1'b0; #2;
    vecs++; if (ctl !== C_HOLD) begin errs++; $display("FAIL br_wait_ctl got %b exp %b", ctl, C_HOLD); end
    step();
    vecs++; if (flush_cnt !== 32'd1) begin errs++; $display("FAIL br_wait_flush got %0d exp 1", flush_cnt); end
    dhit = 1'b1; #2;
    vecs++; if (ctl !== C_BR) begin errs++; $display("FAIL br_release_ctl got %b exp %b", ctl, C_BR); end
    step();
    vecs++; if (flush_cnt !== 32'd2) begin errs++; $display("FAIL br_release_flush got %0d exp 2", flush_cnt); end
  endtask

  task automatic test_dwait();
    do_reset();
    mem_dREN = 1'b1; dhit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      vecs++; if (ctl !== C_HOLD) begin errs++; $display("FAIL dw_ctl[%0d] got %b exp %b", i, ctl, C_HOLD); end
      vecs++; if (state_o !== ((i == 0) ? 2'd0 : 2'd1)) begin errs++; $display("FAIL dw_state[%0d] got %0d exp %0d", i, state_o, (i == 0) ? 0 : 1); end
      step();
    end
    dhit = 1'b1; #2;
    vecs++; if (state_o !== 2'd1) begin errs++; $display("FAIL dw_hit_state got %0d exp 1", state_o); end
    vecs++; if (ctl !== C_RUN) begin errs++; $display("FAIL dw_hit_ctl got %b exp %b", ctl, C_RUN); end
    step();
    mem_dREN = 1'b0; dhit = 1'b0;
    vecs++; if (state_o !== 2'd0) begin errs++; $display("FAIL dw_done_state got %0d exp 0", state_o); end
    vecs++; if (stall_cnt !== 32'd3) begin errs++; $display("FAIL dw_stall got %0d exp 3", stall_cnt); end
    vecs++; if (cycle_cnt !== 32'd4) begin errs++; $display("FAIL dw_cycle got %0d exp 4", cycle_cnt); end
    ihit = 1'b0; #2;
    vecs++; if (ctl !== C_HOLD) begin errs++; $display("FAIL iw_ctl got %b exp %b", ctl, C_HOLD); end
    step();
    vecs++; if (state_o !== 2'd2) begin errs++; $display("FAIL iw_state got %0d exp 2", state_o); end
    ihit = 1'b1; step();
    vecs++; if (state_o !== 2'd0) begin errs++; $display("FAIL iw_done_state got %0d exp 0", state_o); end
  endtask

  task automatic test_watchdog();
    do_reset();
    mem_dREN = 1'b1; dhit = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      #2;
      vecs++; if (ctl !== C_HOLD) begin errs++; $display("FAIL wd_ctl[%0d] got %b exp %b", i, ctl, C_HOLD); end
      step();
      vecs++; if (mem_timeout !== (i >= 6)) begin errs++; $display("FAIL wd_flag[%0d] got %b exp %b", i, mem_timeout, i >= 6); end
    end
    dhit = 1'b1; step();
    mem_dREN = 1'b0; dhit = 1'b0; step();
    vecs++; if (mem_timeout !== 1'b1) begin errs++; $display("FAIL wd_sticky got %b exp 1", mem_timeout); end
    vecs++; if (state_o !== 2'd0) begin errs++; $display("FAIL wd_state got %0d exp 0", state_o); end
  endtask

  task automatic test_halt();
    do_reset();
    ex_br_taken = 1'b1; wb_halt = 1'b1; #2;
    vecs++; if (ctl !== C_BR) begin errs++; $display("FAIL hl_br_ctl got %b exp %b", ctl, C_BR); end
    step();
    ex_br_taken = 1'b0; wb_halt = 1'b0; #1;
    vecs++; if (state_o !== 2'd3) begin errs++; $display("FAIL hl_state got %0d exp 3", state_o); end
    vecs++; if (halt !== 1'b1) begin errs++; $display("FAIL hl_flag got %b exp 1", halt); end
    vecs++; if (ctl !== C_HOLD) begin errs++; $display("FAIL hl_ctl got %b exp %b", ctl, C_HOLD); end
    step(); step();
    vecs++; if (state_o !== 2'd3) begin errs++; $display("FAIL hl_absorb got %0d exp 3", state_o); end
    vecs++; if ({cycle_cnt, stall_cnt, flush_cnt} !== {32'd1, 32'd0, 32'd1}) begin errs++; $display("FAIL hl_frozen got %0d/%0d/%0d exp 1/0/1", cycle_cnt, stall_cnt, flush_cnt); end
    #2; RST = 1'b1; #1;
    vecs++; if (state_o !== 2'd0) begin errs++; $display("FAIL hl_rst_state got %0d exp 0", state_o); end
    vecs++; if ({cycle_cnt, flush_cnt, halt} !== 65'd0) begin errs++; $display("FAIL hl_rst_clear got %0d/%0d/%b exp 0/0/0", cycle_cnt, flush_cnt, halt); end
    #1; RST = 1'b0;
  endtask

  task automatic test_saturate();
    do_reset();
    ihit = 1'b0;
    repeat (9) step();
    vecs++; if (s_cycle !== 3'd7) begin errs++; $display("FAIL sat_cycle got %0d exp 7", s_cycle); end
    vecs++; if (s_stall !== 3'd7) begin errs++; $display("FAIL sat_stall got %0d exp 7", s_stall); end
    vecs++; if (stall_cnt !== 32'd9) begin errs++; $display("FAIL sat_wide_stall got %0d exp 9", stall_cnt); end
    ihit = 1'b1;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_rt_gating();
    test_branch_vs_load_use();
    test_dwait();
    test_watchdog();
    test_halt();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL time_limit got expired exp finished");
    $fatal(1);
  end

endmodule
